icache_direct: RTL

- Direct-mapped, read-only instruction cache between the instruction fetch unit and the memory controller.
- On a hit, it returns the 32-bit instruction one cycle after the request.
- On a miss, it issues a single word-fetch request to the memory controller, holds it until the word returns, fills the line and forwards the word to fetch.
- It supports a flush input for branch mispredictions: an in-flight response is discarded, but the fill still completes, because the memory controller has no abort.

---
 rtl/icache_direct_if.sv | 31 +++
 rtl/icache_direct.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
// Latency: none; this is wiring only.
// Backpressure: fetch_ready gates fetch_req, and the global rdy stalls the whole cache.
interface icache_direct_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              flush;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_ready;
    logic              ins_ok;
    logic [31:0]       ins;
    logic [ADDR_W-1:0] ins_pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ok;
    logic [31:0]       mem_data;

    // Cache-side view.
    modport slave (
        input  rdy, flush, fetch_req, fetch_pc, mem_ok, mem_data,
        output fetch_ready, ins_ok, ins, ins_pc, mem_req, mem_addr
    );

    // Environment-side view: fetch unit, ROB flush and memory controller.
    modport master (
        output rdy, flush, fetch_req, fetch_pc, mem_ok, mem_data,
        input  fetch_ready, ins_ok, ins, ins_pc, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Latency: a hit returns 1 cycle after the request; a miss returns 1 cycle after mem_ok.
// Backpressure: fetch_ready is low while a miss is outstanding; rdy=0 freezes all state.
module icache_direct #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    icache_direct_if.slave      bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic              ins_ok_q, ins_ok_nxt;
    logic [31:0]       ins_q, ins_nxt;
    logic [ADDR_W-1:0] ins_pc_q, ins_pc_nxt;
    logic              mem_req_q, mem_req_nxt;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
    logic [ADDR_W-1:0] miss_pc_q, miss_pc_nxt;
    logic              stale_q, stale_nxt;
    logic              fill_en;

    logic [INDEX_BITS-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0]      req_tag, miss_tag;
    logic [ADDR_W-1:0]     req_pc_word;
    logic                  hit;
    logic                  unused_pc_lsbs;

    assign req_idx        = bus.fetch_pc[INDEX_BITS+1:2];
    assign req_tag        = bus.fetch_pc[ADDR_W-1:INDEX_BITS+2];
    assign req_pc_word    = {bus.fetch_pc[ADDR_W-1:2], 2'b00};
    assign miss_idx       = miss_pc_q[INDEX_BITS+1:2];
    assign miss_tag       = miss_pc_q[ADDR_W-1:INDEX_BITS+2];
    assign hit            = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_pc_lsbs = &{1'b0, bus.fetch_pc[1:0]};

    assign bus.fetch_ready = (state == IDLE);
    assign bus.ins_ok      = ins_ok_q;
    assign bus.ins         = ins_q;
    assign bus.ins_pc      = ins_pc_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;

    // State register; reset wins, otherwise advance only while rdy is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (bus.rdy) begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode for the IDLE/MISS controller.
    always_comb begin
        state_nxt    = state;
        ins_ok_nxt   = 1'b0;
        ins_nxt      = ins_q;
        ins_pc_nxt   = ins_pc_q;
        mem_req_nxt  = mem_req_q;
        mem_addr_nxt = mem_addr_q;
        miss_pc_nxt  = miss_pc_q;
        stale_nxt    = stale_q;
        fill_en      = 1'b0;
        case (state)
            IDLE: begin
                // A flushed request is dropped outright; a late mem_ok here is ignored.
                if (!bus.flush && bus.fetch_req) begin
                    if (hit) begin
                        ins_ok_nxt = 1'b1;
                        ins_nxt    = data_mem[req_idx];
                        ins_pc_nxt = req_pc_word;
                    end else begin
                        miss_pc_nxt  = req_pc_word;
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = req_pc_word;
                        stale_nxt    = 1'b0;
                        state_nxt    = MISS;
                    end
                end
            end
            MISS: begin
                if (bus.mem_ok) begin
                    // The fill always lands; only the response to fetch may be dropped.
                    fill_en     = 1'b1;
                    mem_req_nxt = 1'b0;
                    stale_nxt   = 1'b0;
                    state_nxt   = IDLE;
                    if (!stale_q && !bus.flush) begin
                        ins_ok_nxt = 1'b1;
                        ins_nxt    = bus.mem_data;
                        ins_pc_nxt = miss_pc_q;
                    end
                end else if (bus.flush) begin
                    stale_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, miss bookkeeping and valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            ins_ok_q   <= 1'b0;
            ins_q      <= '0;
            ins_pc_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            miss_pc_q  <= '0;
            stale_q    <= 1'b0;
        end else if (bus.rdy) begin
            ins_ok_q   <= ins_ok_nxt;
            ins_q      <= ins_nxt;
            ins_pc_q   <= ins_pc_nxt;
            mem_req_q  <= mem_req_nxt;
            mem_addr_q <= mem_addr_nxt;
            miss_pc_q  <= miss_pc_nxt;
            stale_q    <= stale_nxt;
            if (fill_en) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (!rst && bus.rdy && fill_en) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= bus.mem_data;
        end
    end
endmodule
